// File: rtl/freq_calc.sv
// Measurement controller for the frequency/duty counter stage: opens a gate window,
// waits for the counts to settle, then divides them into freq_hz and duty_pm.
module freq_calc #(
  parameter int unsigned CLK_HZ        = 200000000,
  parameter int unsigned GATE_CYCLES   = 200000000,
  parameter int unsigned SETTLE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        gate,
  input  logic [31:0] x_count,
  input  logic [31:0] r_count,
  input  logic [31:0] xh_count,
  input  logic [31:0] xl_count,
  output logic        busy,
  output logic        done,
  output logic [31:0] freq_hz,
  output logic [9:0]  duty_pm,
  output logic        err,
  output logic        ovf
);

  localparam logic [31:0] GATE_LOAD   = 32'(GATE_CYCLES - 1);
  localparam logic [31:0] SETTLE_LOAD = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0] DIV_LOAD    = 32'd63;
  localparam logic [63:0] CLK_MULT    = 64'(CLK_HZ);
  localparam logic [63:0] DUTY_SCALE  = 64'd1000;
  localparam logic [63:0] DUTY_MAX    = 64'd1000;

  typedef enum logic [2:0] {
    IDLE,
    GATE,
    SETTLE,
    CAP,
    DIV_F,
    DIV_D,
    DONE
  } state_t;

  state_t      state;
  logic [31:0] cnt;
  logic [63:0] quo;
  logic [32:0] rem;
  logic [31:0] r_cap;
  logic [31:0] xh_cap;
  logic [32:0] dd;
  logic [31:0] freq_pend;
  logic [9:0]  duty_pend;
  logic        ovf_pend;
  logic        err_pend;

  logic [32:0] divisor;
  logic [33:0] trial;
  logic        fits;
  logic [32:0] rem_next;
  logic [63:0] quo_next;

  // One restoring-division step shared by both divisions; the divisor follows the state.
  always_comb begin
    divisor  = (state == DIV_D) ? dd : {1'b0, r_cap};
    trial    = {rem, quo[63]};
    fits     = (trial >= {1'b0, divisor});
    rem_next = fits ? 33'(trial - {1'b0, divisor}) : trial[32:0];
    quo_next = {quo[62:0], fits};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      quo       <= '0;
      rem       <= '0;
      r_cap     <= '0;
      xh_cap    <= '0;
      dd        <= '0;
      freq_pend <= '0;
      duty_pend <= '0;
      ovf_pend  <= 1'b0;
      err_pend  <= 1'b0;
      gate      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      freq_hz   <= '0;
      duty_pm   <= '0;
      err       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          // busy stays up for the done cycle, so a start arriving then is ignored
          if (busy) begin
            busy <= 1'b0;
          end else if (start) begin
            busy  <= 1'b1;
            gate  <= 1'b1;
            cnt   <= GATE_LOAD;
            state <= GATE;
          end
        end

        GATE: begin
          if (cnt == 32'd0) begin
            gate  <= 1'b0;
            cnt   <= SETTLE_LOAD;
            state <= SETTLE;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end

        SETTLE: begin
          if (cnt == 32'd0) begin
            state <= CAP;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end

        CAP: begin
          quo    <= 64'(x_count) * CLK_MULT;
          rem    <= '0;
          r_cap  <= r_count;
          xh_cap <= xh_count;
          dd     <= {1'b0, xh_count} + {1'b0, xl_count};
          cnt    <= DIV_LOAD;
          state  <= DIV_F;
        end

        DIV_F: begin
          rem <= rem_next;
          quo <= quo_next;
          if (cnt == 32'd0) begin
            if (r_cap == 32'd0) begin
              freq_pend <= '0;
              ovf_pend  <= 1'b0;
              err_pend  <= 1'b1;
            end else if (quo_next[63:32] != 32'd0) begin
              freq_pend <= 32'hFFFF_FFFF;
              ovf_pend  <= 1'b1;
              err_pend  <= 1'b0;
            end else begin
              freq_pend <= quo_next[31:0];
              ovf_pend  <= 1'b0;
              err_pend  <= 1'b0;
            end
            quo   <= 64'(xh_cap) * DUTY_SCALE;
            rem   <= '0;
            cnt   <= DIV_LOAD;
            state <= DIV_D;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end

        DIV_D: begin
          rem <= rem_next;
          quo <= quo_next;
          if (cnt == 32'd0) begin
            // xh never exceeds xh+xl, so the clamp only guards against bad inputs
            if (dd == 33'd0) begin
              duty_pend <= '0;
              err_pend  <= 1'b1;
            end else if (quo_next > DUTY_MAX) begin
              duty_pend <= DUTY_MAX[9:0];
            end else begin
              duty_pend <= quo_next[9:0];
            end
            state <= DONE;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end

        DONE: begin
          freq_hz <= freq_pend;
          duty_pm <= duty_pend;
          ovf     <= ovf_pend;
          err     <= err_pend;
          done    <= 1'b1;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_calc.sv
// Scoreboard bench for freq_calc: stimulus pushes expected results, a monitor
// checks them on each done pulse along with latency and gate width.
module tb_freq_calc;

  localparam int unsigned CLK_HZ        = 200000000;
  localparam int unsigned GATE_CYCLES   = 100;
  localparam int unsigned SETTLE_CYCLES = 8;
  localparam longint      LATENCY       = 1 + GATE_CYCLES + SETTLE_CYCLES + 1 + 64 + 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        gate;
  logic [31:0] x_count = '0;
  logic [31:0] r_count = '0;
  logic [31:0] xh_count = '0;
  logic [31:0] xl_count = '0;
  logic        busy;
  logic        done;
  logic [31:0] freq_hz;
  logic [9:0]  duty_pm;
  logic        err;
  logic        ovf;

  typedef struct {
    logic [31:0] freq;
    logic [9:0]  duty;
    logic        err;
    logic        ovf;
    longint      cyc;
  } exp_t;

  exp_t   sb[$];
  exp_t   mon_exp;
  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  int     gate_len = 0;
  logic   done_prev = 1'b0;

  freq_calc #(
    .CLK_HZ(CLK_HZ),
    .GATE_CYCLES(GATE_CYCLES),
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .gate(gate),
    .x_count(x_count),
    .r_count(r_count),
    .xh_count(xh_count),
    .xl_count(xl_count),
    .busy(busy),
    .done(done),
    .freq_hz(freq_hz),
    .duty_pm(duty_pm),
    .err(err),
    .ovf(ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drive the counter-stage stub values and pulse start for 'hold' cycles.
  task automatic applyStimulus(input logic [31:0] x, input logic [31:0] r, input logic [31:0] xh,
                               input logic [31:0] xl, input logic [31:0] f, input logic [9:0] d,
                               input logic e, input logic o, input int hold);
    exp_t item;
    @(negedge clk);
    x_count  = x;
    r_count  = r;
    xh_count = xh;
    xl_count = xl;
    start    = 1'b1;
    item.freq = f;
    item.duty = d;
    item.err  = e;
    item.ovf  = o;
    item.cyc  = cyc + 1 + LATENCY;
    sb.push_back(item);
    repeat (hold) @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    for (n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) break;
    end
    if (n == 1000) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_idle: timed out, busy=%0b pending=%0d", busy, sb.size());
    end
  endtask

  task automatic checkCleared(input string tag);
    checkOutput({tag, "_gate"}, 64'(gate), 64'd0);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_done"}, 64'(done), 64'd0);
    checkOutput({tag, "_freq"}, 64'(freq_hz), 64'd0);
    checkOutput({tag, "_duty"}, 64'(duty_pm), 64'd0);
    checkOutput({tag, "_err"}, 64'(err), 64'd0);
    checkOutput({tag, "_ovf"}, 64'(ovf), 64'd0);
  endtask

  task automatic abortWithReset(input int wait_cycles, input string tag);
    repeat (wait_cycles) @(negedge clk);
    #2 rst = 1'b1;
    #1 checkCleared(tag);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (rst) begin
      done_prev = 1'b0;
    end else begin
      if (done_prev) checkOutput("done_one_cycle", 64'(done), 64'd0);
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
        end else begin
          mon_exp = sb.pop_front();
          checkOutput("freq_hz", 64'(freq_hz), 64'(mon_exp.freq));
          checkOutput("duty_pm", 64'(duty_pm), 64'(mon_exp.duty));
          checkOutput("err", 64'(err), 64'(mon_exp.err));
          checkOutput("ovf", 64'(ovf), 64'(mon_exp.ovf));
          checkOutput("latency", 64'(cyc), 64'(mon_exp.cyc));
          checkOutput("busy_at_done", 64'(busy), 64'd1);
        end
      end
      done_prev = done;
    end
  end

  // Gate width monitor: every completed window must be exactly GATE_CYCLES long.
  always @(negedge clk) begin
    if (rst) begin
      gate_len = 0;
    end else if (gate) begin
      gate_len++;
    end else if (gate_len != 0) begin
      checkOutput("gate_width", 64'(gate_len), 64'(GATE_CYCLES));
      gate_len = 0;
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    checkCleared("reset");
    rst = 1'b0;
    @(negedge clk);
    checkCleared("post_reset");

    applyStimulus(1000, 200000, 60000, 140000, 32'd1000000, 10'd300, 1'b0, 1'b0, 1);
    waitIdle();

    // start held well into the measurement must not queue a second one
    applyStimulus(1000, 200000, 60000, 140000, 32'd1000000, 10'd300, 1'b0, 1'b0, 60);
    waitIdle();
    repeat (20) @(negedge clk);
    checkOutput("no_relaunch_busy", 64'(busy), 64'd0);
    checkOutput("no_relaunch_gate", 64'(gate), 64'd0);
    checkOutput("hold_freq", 64'(freq_hz), 64'd1000000);

    applyStimulus(1000, 0, 5, 5, 32'd0, 10'd500, 1'b1, 1'b0, 1);
    waitIdle();
    applyStimulus(32'hFFFF_FFFF, 1, 1, 1, 32'hFFFF_FFFF, 10'd500, 1'b0, 1'b1, 1);
    waitIdle();
    applyStimulus(3, 7, 0, 9, 32'd85714285, 10'd0, 1'b0, 1'b0, 1);
    waitIdle();
    applyStimulus(3, 7, 7, 0, 32'd85714285, 10'd1000, 1'b0, 1'b0, 1);
    waitIdle();
    applyStimulus(3, 7, 0, 0, 32'd85714285, 10'd0, 1'b1, 1'b0, 1);
    waitIdle();

    applyStimulus(1000, 200000, 60000, 140000, 32'd1000000, 10'd300, 1'b0, 1'b0, 1);
    abortWithReset(40, "rst_gate");

    applyStimulus(32'hFFFF_FFFF, 1, 1, 1, 32'hFFFF_FFFF, 10'd500, 1'b0, 1'b1, 1);
    waitIdle();
    applyStimulus(1000, 200000, 60000, 140000, 32'd1000000, 10'd300, 1'b0, 1'b0, 1);
    abortWithReset(1 + GATE_CYCLES + SETTLE_CYCLES + 1 + 10, "rst_divf");

    applyStimulus(1000, 200000, 60000, 140000, 32'd1000000, 10'd300, 1'b0, 1'b0, 1);
    waitIdle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/freq_calc.md
Name: freq_calc

Overview:
- Measurement controller and post-processor for the frequency/duty counter stage.
- Drives that stage's gate input with a programmable-length window, then waits for its count outputs to settle.
- Captures x_count, r_count, xh_count and xl_count, and converts them with a shared 64-bit sequential restoring divider.
- Results: frequency in Hz and duty cycle in permille, presented with a one-cycle done pulse.

Parameters:
- CLK_HZ, 200000000, reference clock frequency in Hz; the constant multiplier for the frequency result.
- GATE_CYCLES, 200000000, number of clk cycles gate is held high (1 s at 200 MHz); minimum 1.
- SETTLE_CYCLES, 16, number of clk cycles gate is held low before the counts are captured; minimum 4.

Ports:
- clk  in  1  reference clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  measurement request; sampled only in IDLE.
- gate  out  1  gate window to the counter stage.
- x_count  in  32  input rising edges in the gate (from counter stage).
- r_count  in  32  reference clocks in the gate (from counter stage).
- xh_count  in  32  reference clocks with input high.
- xl_count  in  32  reference clocks with input low.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse; results valid from this cycle.
- freq_hz  out  32  floor(x_count*CLK_HZ/r_count), saturated.
- duty_pm  out  10  floor(xh_count*1000/(xh_count+xl_count)), range 0..1000.
- err  out  1  last measurement invalid; updated at done.
- ovf  out  1  freq_hz saturated; updated at done.

Behaviour:
- Reset values (asynchronous): gate=0, busy=0, done=0, freq_hz=0, duty_pm=0, err=0, ovf=0, FSM=IDLE, all counters and datapath registers 0.
- Reset mid-operation aborts immediately: gate drops in the same instant, and no done pulse is issued.
- IDLE:
  - start=1 moves the FSM to GATE on the next edge.
  - busy and gate rise on that same edge.
  - start while busy is ignored, with no queueing.
- GATE:
  - gate=1 for exactly GATE_CYCLES cycles, using an internal down-counter.
  - Then gate=0 and the FSM moves to SETTLE.
- SETTLE:
  - gate=0 for SETTLE_CYCLES cycles.
  - This covers the counter stage's gate resynchronisation to input edges plus its latch cycle.
  - If the input is static, the counts stay stale or zero; this is caught by the err checks.
- CAP, 1 cycle:
  - Register all four counts.
  - Compute the 64-bit numerator NF = x_count*CLK_HZ (single-cycle multiply into a registered product).
  - Compute the 33-bit denominator DD = xh_count+xl_count.
- DIV_F, 64 cycles:
  - Restoring division NF / r_count, one quotient bit per cycle, MSB first.
  - Uses a 33-bit partial remainder and a 64-bit quotient shift register.
- DIV_D, 64 cycles:
  - Same divider, numerator xh_count*1000 zero-extended to 64 bits, divisor DD.
- DONE, 1 cycle:
  - Outputs update and done=1.
  - busy falls on the following edge, and the FSM returns to IDLE.
- Latency: done asserts exactly 1+GATE_CYCLES+SETTLE_CYCLES+1+64+64 cycles after the start-sampling edge.
- Truncation only; no rounding.
- Frequency saturation: if the 64-bit quotient exceeds 2^32-1, freq_hz=32'hFFFFFFFF and ovf=1; otherwise ovf=0.
- Division by zero:
  - r_count==0: freq_hz=0, err=1. The divider still runs its cycles, so latency is fixed.
  - DD==0: duty_pm=0, err=1.
- Otherwise err=0.
- duty_pm never exceeds 1000, because xh_count<=DD.
- Outputs hold their last values between measurements; a new measurement overwrites them only at its done.

Test Plan:
- CLK_HZ=200e6, GATE_CYCLES=100, SETTLE_CYCLES=8, stub drives x_count=1000, r_count=200000, xh=60000, xl=140000 -> freq_hz=1000000, duty_pm=300, err=0, ovf=0, done exactly 1+100+8+129 cycles after start.
- Gate timing: pulse start -> gate high for exactly 100 cycles, busy high through done, a start held during busy is ignored, and after done a single start launches exactly one new measurement.
- r_count=0 with xh=5, xl=5 -> freq_hz=0, duty_pm=500, err=1; same latency.
- Saturation: x_count=32'hFFFFFFFF, r_count=1 -> freq_hz=32'hFFFFFFFF, ovf=1; then x_count=3, r_count=7 -> freq_hz=85714285 (truncated), ovf=0.
- Duty bounds: xh=0, xl=9 -> duty_pm=0; xh=7, xl=0 -> duty_pm=1000; xh=xl=0 -> duty_pm=0, err=1.
- Assert rst during GATE and again during DIV_F -> gate, busy and done are 0 immediately, outputs are cleared, and the next start runs a clean measurement with correct results.
